// File: rtl/operand_fetch_pipe.sv
// Operand-fetch stage: decode, register read with writeback bypass,
// scoreboard hazard stall and a valid/ready output register.
module operand_fetch_pipe #(
  parameter  int DATA_W  = 64,
  parameter  int REG_AW  = 4,
  parameter  int OPC_W   = 4,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = OPC_W + 3*REG_AW,
  localparam int NREG    = 2**REG_AW,
  localparam int CTRL_W  = 2**OPC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [PC_W-1:0]     out_pc,
  output logic [DATA_W-1:0]   out_op_a,
  output logic [DATA_W-1:0]   out_op_b,
  output logic                out_flag,
  output logic [2*REG_AW-1:0] out_addr,
  output logic                out_we,
  output logic [REG_AW-1:0]   out_dest
);

  logic [OPC_W-1:0]    opc;
  logic [REG_AW-1:0]   ra;
  logic [REG_AW-1:0]   rb;
  logic [REG_AW-1:0]   rc;
  logic [REG_AW-1:0]   dest;
  logic                we;
  logic [CTRL_W-1:0]   ctrl;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                byp_a;
  logic                byp_b;
  logic                byp_d;
  logic                hazard;
  logic                load;
  logic                issue;

  logic [DATA_W-1:0]   rf_q [NREG];
  logic [NREG-1:0]     pend_q;
  logic [NREG-1:0]     pend_d;

  logic                valid_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                flag_q;
  logic [2*REG_AW-1:0] addr_q;
  logic                we_q;
  logic [REG_AW-1:0]   dest_q;

  assign opc  = in_instr[OPC_W-1:0];
  assign ra   = in_instr[OPC_W +: REG_AW];
  assign rb   = in_instr[OPC_W+REG_AW +: REG_AW];
  assign rc   = in_instr[OPC_W+2*REG_AW +: REG_AW];
  assign we   = !opc[OPC_W-1];
  assign dest = (opc < OPC_W'(3)) ? rc : ra;

  // one-hot control rod from the opcode
  always_comb begin
    ctrl      = '0;
    ctrl[opc] = 1'b1;
  end

  assign byp_a = wb_en && (wb_addr == ra);
  assign byp_b = wb_en && (wb_addr == rb);
  assign byp_d = wb_en && (wb_addr == dest);
  assign op_a  = byp_a ? wb_data : rf_q[ra];
  assign op_b  = byp_b ? wb_data : rf_q[rb];

  // stall on pending registers and on the writer still held at the output
  always_comb begin
    hazard = 1'b0;
    if (pend_q[ra] && !byp_a)
      hazard = 1'b1;
    if (pend_q[rb] && !byp_b)
      hazard = 1'b1;
    if (we && pend_q[dest] && !byp_d)
      hazard = 1'b1;
    if (valid_q && we_q &&
        (dest_q == ra || dest_q == rb ||
         (we && dest_q == dest)))
      hazard = 1'b1;
  end

  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign load     = in_valid && in_ready;
  assign issue    = valid_q && out_ready && we_q && !flush;

  // scoreboard next state: clear on writeback, issue set takes priority
  always_comb begin
    pend_d = pend_q;
    if (wb_en)
      pend_d[wb_addr] = 1'b0;
    if (issue)
      pend_d[dest_q] = 1'b1;
  end

  // scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  // register file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // output valid: set on load, dropped on accept or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid_q <= 1'b0;
    else if (load)
      valid_q <= 1'b1;
    else if (out_ready || flush)
      valid_q <= 1'b0;
  end

  // output payload: captured only on load so it holds under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      pc_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      flag_q <= 1'b0;
      addr_q <= '0;
      we_q   <= 1'b0;
      dest_q <= '0;
    end else if (load) begin
      ctrl_q <= ctrl;
      pc_q   <= in_pc;
      a_q    <= op_a;
      b_q    <= op_b;
      flag_q <= (op_a == op_b);
      addr_q <= {rc, rb};
      we_q   <= we;
      dest_q <= dest;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_pc    = pc_q;
  assign out_op_a  = a_q;
  assign out_op_b  = b_q;
  assign out_flag  = flag_q;
  assign out_addr  = addr_q;
  assign out_we    = we_q;
  assign out_dest  = dest_q;

endmodule
